// File: rtl/fx2_fifo_writer_if.sv
// FX2 slave-FIFO bus plus the read side of the CDC FIFO, as seen by the write engine.
// master = write engine, slave = FIFO/endpoint side.
interface fx2_fifo_writer_if;
  logic [15:0] fifo_data_i;
  logic        fifo_valid_i;
  logic        fifo_ren_o;
  logic        flagb_i;
  logic        slwr_o;
  logic        pktend_o;
  logic [15:0] fd_o;

  modport master (
    input  fifo_data_i, fifo_valid_i, flagb_i,
    output fifo_ren_o, slwr_o, pktend_o, fd_o
  );

  modport slave (
    output fifo_data_i, fifo_valid_i, flagb_i,
    input  fifo_ren_o, slwr_o, pktend_o, fd_o
  );
endinterface

// File: rtl/fx2_fifo_writer.sv
// FX2 slave-FIFO write engine: pops CDC FIFO words or xorshift test data into the endpoint,
// tracks per-packet word count and commits short packets on flush or idle timeout.
module fx2_fifo_writer #(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic [15:0] SEED         = 16'h6c41
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     test_i,
  fx2_fifo_writer_if.master        bus,
  output logic                     test_mode_o,
  output logic [31:0]              words_o
);

  localparam int unsigned WCW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned IW  = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(PKT_WORDS - 1);
  localparam logic [IW-1:0]  IDLE_MAX = IW'(IDLE_TIMEOUT);

  typedef enum logic {CAP, TEST} mode_t;

  mode_t          mode_q, mode_d;
  logic           pend_q, pend_d;
  logic [WCW-1:0] w_cnt_q, w_cnt_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           flush_pend_q, flush_pend_d;
  logic [15:0]    rng_q, rng_d;
  logic [31:0]    words_q, words_d;

  logic sw, go, wr, last;

  function automatic logic [15:0] xs(input logic [15:0] s);
    logic [15:0] t1, t2;
    t1 = s ^ (s << 7);
    t2 = t1 ^ (t1 >> 9);
    return t2 ^ (t2 << 8);
  endfunction

  always_comb begin
    last = (w_cnt_q == W_LAST);
    // Mode may only change on a packet boundary; the switching cycle carries no write.
    sw = !pend_q && (w_cnt_q == '0) && ((mode_q == CAP) ? test_i : !test_i);
    go = (mode_q == CAP) && !pend_q && (w_cnt_q != '0) && !bus.flagb_i &&
         (flush_i || flush_pend_q || (idle_q == IDLE_MAX));
    if (mode_q == CAP) wr = !pend_q && !go && !sw && bus.fifo_valid_i && !bus.flagb_i;
    else               wr = !pend_q && !sw && !bus.flagb_i;

    bus.slwr_o     = wr && !reset_i;
    bus.fifo_ren_o = wr && (mode_q == CAP) && !reset_i;
    bus.pktend_o   = pend_q;
    if (reset_i)             bus.fd_o = '0;
    else if (mode_q == CAP)  bus.fd_o = bus.fifo_data_i;
    else                     bus.fd_o = rng_q;

    mode_d       = mode_q;
    pend_d       = pend_q;
    w_cnt_d      = w_cnt_q;
    idle_d       = idle_q;
    flush_pend_d = flush_pend_q;
    rng_d        = rng_q;
    words_d      = words_q + 32'(wr);

    if (pend_q) begin
      pend_d       = 1'b0;
      w_cnt_d      = '0;
      idle_d       = '0;
      flush_pend_d = 1'b0;
    end else begin
      pend_d = go;
      // A flush with nothing written and nothing being written would be a zero-length packet.
      if ((mode_q == CAP) && flush_i && !go && !((w_cnt_q == '0) && !wr))
        flush_pend_d = 1'b1;
      if (wr) begin
        idle_d  = '0;
        w_cnt_d = last ? '0 : w_cnt_q + 1'b1;
        if (last) flush_pend_d = 1'b0;
        if (mode_q == TEST) rng_d = xs(rng_q);
      end else if ((mode_q == CAP) && (w_cnt_q != '0)) begin
        if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
      end else begin
        idle_d = '0;
      end
      if (sw) begin
        if (mode_q == CAP) begin
          mode_d = TEST;
        end else begin
          mode_d = CAP;
          rng_d  = SEED;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q       <= CAP;
      pend_q       <= 1'b0;
      w_cnt_q      <= '0;
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
      rng_q        <= SEED;
      words_q      <= '0;
    end else begin
      mode_q       <= mode_d;
      pend_q       <= pend_d;
      w_cnt_q      <= w_cnt_d;
      idle_q       <= idle_d;
      flush_pend_q <= flush_pend_d;
      rng_q        <= rng_d;
      words_q      <= words_d;
    end
  end

  assign test_mode_o = (mode_q == TEST);
  assign words_o     = words_q;

endmodule
